// File: rtl/lsu_pkg.sv
// Shared types and constants for the byte-memory load/store unit.
// FSM states, access-size encoding and the memory read latency.
package lsu_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LD0  = 3'd1,
        LD1  = 3'd2,
        LD2  = 3'd3,
        ST0  = 3'd4,
        ST1  = 3'd5,
        RESP = 3'd6
    } lsu_state_e;

    localparam logic SIZE_BYTE      = 1'b0;
    localparam logic SIZE_HALF      = 1'b1;
    localparam int   MEM_RD_LATENCY = 1;

endpackage

// File: rtl/lsu_if.sv
// CPU request/response handshake plus byte-memory port of the load/store unit.
// slave = the unit itself, master = the CPU/memory environment around it.
interface lsu_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) ();

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic                  req_size;
    logic                  req_signed;
    logic [ADDR_W-1:0]     req_addr;
    logic [2*DATA_W-1:0]   req_wdata;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [2*DATA_W-1:0]   resp_rdata;
    logic                  mem_write;
    logic [ADDR_W-1:0]     mem_address;
    logic [DATA_W-1:0]     mem_input_data;
    logic [DATA_W-1:0]     mem_output_data;

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  resp_ready, mem_output_data,
        output req_ready, resp_valid, resp_rdata,
        output mem_write, mem_address, mem_input_data
    );

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output resp_ready, mem_output_data,
        input  req_ready, resp_valid, resp_rdata,
        input  mem_write, mem_address, mem_input_data
    );

endinterface

// File: rtl/load_store_unit.sv
// Sequences byte/halfword loads and stores into little-endian byte accesses
// on a single-port memory whose read data arrives one cycle after the address.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic  clk,
    input  logic  rst_n,
    lsu_if.slave  bus
);

    lsu_state_e            state_q, state_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic                  size_q, size_d;
    logic                  signed_q, signed_d;
    logic [DATA_W-1:0]     wdata_hi_q, wdata_hi_d;
    logic [DATA_W-1:0]     lo_q, lo_d;
    logic [2*DATA_W-1:0]   rdata_q, rdata_d;
    logic                  resp_valid_q, resp_valid_d;
    logic                  req_ready_q, req_ready_d;
    logic                  mem_write_q, mem_write_d;
    logic [ADDR_W-1:0]     mem_address_q, mem_address_d;
    logic [DATA_W-1:0]     mem_input_data_q, mem_input_data_d;
    logic [ADDR_W-1:0]     addr_inc_s;

    // Second byte of a halfword; wraps naturally at the top of the address space.
    assign addr_inc_s = addr_q + ADDR_W'(1'b1);

    // Next-state and registered-output decode.
    always_comb begin
        state_d          = state_q;
        addr_d           = addr_q;
        size_d           = size_q;
        signed_d         = signed_q;
        wdata_hi_d       = wdata_hi_q;
        lo_d             = lo_q;
        rdata_d          = rdata_q;
        resp_valid_d     = resp_valid_q;
        req_ready_d      = req_ready_q;
        mem_write_d      = mem_write_q;
        mem_address_d    = mem_address_q;
        mem_input_data_d = mem_input_data_q;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    addr_d        = bus.req_addr;
                    size_d        = bus.req_size;
                    signed_d      = bus.req_signed;
                    wdata_hi_d    = bus.req_wdata[2*DATA_W-1:DATA_W];
                    req_ready_d   = 1'b0;
                    mem_address_d = bus.req_addr;
                    if (bus.req_write) begin
                        state_d          = ST0;
                        mem_write_d      = 1'b1;
                        mem_input_data_d = bus.req_wdata[DATA_W-1:0];
                        rdata_d          = '0;
                    end else begin
                        state_d     = LD0;
                        mem_write_d = 1'b0;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            LD0: begin
                state_d = LD1;
                if (size_q == SIZE_HALF) begin
                    mem_address_d = addr_inc_s;
                end else begin
                    mem_address_d = addr_q;
                end
            end
            LD1: begin
                lo_d = bus.mem_output_data;
                if (size_q == SIZE_BYTE) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    rdata_d      = {{DATA_W{signed_q & bus.mem_output_data[DATA_W-1]}},
                                    bus.mem_output_data};
                end else begin
                    state_d = LD2;
                end
            end
            LD2: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
                rdata_d      = {bus.mem_output_data, lo_q};
            end
            ST0: begin
                if (size_q == SIZE_HALF) begin
                    state_d          = ST1;
                    mem_write_d      = 1'b1;
                    mem_address_d    = addr_inc_s;
                    mem_input_data_d = wdata_hi_q;
                end else begin
                    state_d      = RESP;
                    mem_write_d  = 1'b0;
                    resp_valid_d = 1'b1;
                end
            end
            ST1: begin
                state_d      = RESP;
                mem_write_d  = 1'b0;
                resp_valid_d = 1'b1;
            end
            RESP: begin
                if (bus.resp_ready) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d      = IDLE;
                req_ready_d  = 1'b1;
                resp_valid_d = 1'b0;
                mem_write_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            addr_q           <= '0;
            size_q           <= SIZE_BYTE;
            signed_q         <= 1'b0;
            wdata_hi_q       <= '0;
            lo_q             <= '0;
            rdata_q          <= '0;
            resp_valid_q     <= 1'b0;
            req_ready_q      <= 1'b1;
            mem_write_q      <= 1'b0;
            mem_address_q    <= '0;
            mem_input_data_q <= '0;
        end else begin
            state_q          <= state_d;
            addr_q           <= addr_d;
            size_q           <= size_d;
            signed_q         <= signed_d;
            wdata_hi_q       <= wdata_hi_d;
            lo_q             <= lo_d;
            rdata_q          <= rdata_d;
            resp_valid_q     <= resp_valid_d;
            req_ready_q      <= req_ready_d;
            mem_write_q      <= mem_write_d;
            mem_address_q    <= mem_address_d;
            mem_input_data_q <= mem_input_data_d;
        end
    end

    assign bus.req_ready      = req_ready_q;
    assign bus.resp_valid     = resp_valid_q;
    assign bus.resp_rdata     = rdata_q;
    assign bus.mem_write      = mem_write_q;
    assign bus.mem_address    = mem_address_q;
    assign bus.mem_input_data = mem_input_data_q;

endmodule
